alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 107 ++++++++++
 tb/tb_alu_exec.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Single-cycle ALU execute stage: combinational ALU-control decode plus a registered
// ALU result, zero flag and independent branch/PC adder sum.
module alu_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [5:0]       funct,
    input  logic             alu_op0,
    input  logic             alu_op1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [2:0]       alu_ctrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] add_sum
);

    localparam int unsigned CTRL_W = 3;

    localparam logic [CTRL_W-1:0] CTRL_AND = 3'b000;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 3'b001;
    localparam logic [CTRL_W-1:0] CTRL_ADD = 3'b010;
    localparam logic [CTRL_W-1:0] CTRL_NOR = 3'b100;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 3'b110;
    localparam logic [CTRL_W-1:0] CTRL_SLT = 3'b111;

    logic [CTRL_W-1:0] ctrl_c;
    logic [WIDTH-1:0]  alu_res_c;

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic [WIDTH-1:0] sum_q,    sum_d;

    // ALU-control decode; ALUOp=11 is treated like 00 (add)
    always_comb begin
        ctrl_c = CTRL_ADD;
        unique case ({alu_op1, alu_op0})
            2'b01:   ctrl_c = CTRL_SUB;
            2'b10: begin
                unique case (funct)
                    6'b100000: ctrl_c = CTRL_ADD;
                    6'b100010: ctrl_c = CTRL_SUB;
                    6'b100100: ctrl_c = CTRL_AND;
                    6'b100101: ctrl_c = CTRL_OR;
                    6'b100111: ctrl_c = CTRL_NOR;
                    6'b101010: ctrl_c = CTRL_SLT;
                    default:   ctrl_c = CTRL_ADD;
                endcase
            end
            default: ctrl_c = CTRL_ADD;
        endcase
    end

    // Datapath; unused control codes produce zero
    always_comb begin
        alu_res_c = '0;
        unique case (ctrl_c)
            CTRL_AND: alu_res_c = a & b;
            CTRL_OR:  alu_res_c = a | b;
            CTRL_ADD: alu_res_c = a + b;
            CTRL_SUB: alu_res_c = a - b;
            CTRL_NOR: alu_res_c = ~(a | b);
            CTRL_SLT: alu_res_c = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            default:  alu_res_c = '0;
        endcase
    end

    // Capture on valid, otherwise hold the previous result
    always_comb begin
        valid_d  = in_valid;
        result_d = result_q;
        zero_d   = zero_q;
        sum_d    = sum_q;
        if (in_valid) begin
            result_d = alu_res_c;
            zero_d   = (alu_res_c == '0);
            sum_d    = add_a + add_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            sum_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            sum_q    <= sum_d;
        end
    end

    assign alu_ctrl   = ctrl_c;
    assign out_valid  = valid_q;
    assign alu_result = result_q;
    assign zero       = zero_q;
    assign add_sum    = sum_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected results are queued at drive time and
// compared one edge later against the registered outputs.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  funct;
    logic        alu_op0, alu_op1;
    logic [31:0] a, b, add_a, add_b;
    logic [2:0]  alu_ctrl;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] add_sum;

    typedef struct packed {
        logic [31:0] res;
        logic        zf;
        logic [31:0] sum;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .funct      (funct),
        .alu_op0    (alu_op0),
        .alu_op1    (alu_op1),
        .a          (a),
        .b          (b),
        .add_a      (add_a),
        .add_b      (add_b),
        .alu_ctrl   (alu_ctrl),
        .out_valid  (out_valid),
        .alu_result (alu_result),
        .zero       (zero),
        .add_sum    (add_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 3'b110;
        if (op != 2'b10) return 3'b010;
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h27:   return 3'b100;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b100:  return ~(x | y);
            3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive at negedge, check decode, queue expectation, check after posedge
    task automatic cycle(input logic rst, input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] pa, input logic [31:0] pb);
        exp_t e;
        logic [31:0] r;
        @(negedge clk);
        rst_n = rst; in_valid = v; {alu_op1, alu_op0} = op; funct = f;
        a = xa; b = xb; add_a = pa; add_b = pb;
        #1;
        check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl(op, f)));
        if (rst && v) begin
            r = m_alu(m_ctrl(op, f), xa, xb);
            e.res = r; e.zf = (r == 32'd0); e.sum = pa + pb;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_q.delete();
            last_exp = '{res: 32'd0, zf: 1'b1, sum: 32'd0};
        end else if (v) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
            end
        end
        check("out_valid", 32'(out_valid), 32'(rst && v));
        check("alu_result", alu_result, last_exp.res);
        check("zero", 32'(zero), 32'(last_exp.zf));
        check("add_sum", add_sum, last_exp.sum);
    endtask

    initial begin
        logic [5:0] fl[7];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
        last_exp = '{res: 32'd0, zf: 1'b1, sum: 32'd0};
        rst_n = 1'b0; in_valid = 1'b0; funct = '0; alu_op0 = 1'b0; alu_op1 = 1'b0;
        a = '0; b = '0; add_a = '0; add_b = '0;

        // Reset overrides a valid input
        cycle(1'b0, 1'b1, 2'b00, 6'h00, 32'h11, 32'h22, 32'h33, 32'h44);
        cycle(1'b0, 1'b1, 2'b00, 6'h00, 32'h1, 32'h2, 32'h3, 32'h4);

        // Decode sweep
        cycle(1'b1, 1'b1, 2'b00, 6'h22, 32'd9, 32'd4, 32'd0, 32'd0);
        cycle(1'b1, 1'b1, 2'b01, 6'h20, 32'd9, 32'd4, 32'd0, 32'd0);
        cycle(1'b1, 1'b1, 2'b11, 6'h22, 32'd9, 32'd4, 32'd0, 32'd0);
        for (int i = 0; i < 7; i++)
            cycle(1'b1, 1'b1, 2'b10, fl[i], 32'h1357_9BDF, 32'h0246_8ACE, 32'(i), 32'd100);

        // Arithmetic and zero flag
        cycle(1'b1, 1'b1, 2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        check("wrap_add_zero", 32'(zero), 32'd1);
        cycle(1'b1, 1'b1, 2'b10, 6'h22, 32'd5, 32'd7, 32'd0, 32'd0);
        check("sub_neg", alu_result, 32'hFFFF_FFFE);
        cycle(1'b1, 1'b1, 2'b01, 6'h00, 32'h1234, 32'h1234, 32'd0, 32'd0);
        check("beq_zero", 32'(zero), 32'd1);

        // Logic and signed compare
        cycle(1'b1, 1'b1, 2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0);
        check("and", alu_result, 32'h00F0_00F0);
        cycle(1'b1, 1'b1, 2'b10, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0);
        check("or", alu_result, 32'hFFF0_FFF0);
        cycle(1'b1, 1'b1, 2'b10, 6'h27, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0);
        check("nor", alu_result, 32'h000F_000F);
        cycle(1'b1, 1'b1, 2'b10, 6'h2A, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
        check("slt_neg", alu_result, 32'd1);
        cycle(1'b1, 1'b1, 2'b10, 6'h2A, 32'd0, 32'h8000_0000, 32'd0, 32'd0);
        check("slt_pos", alu_result, 32'd0);
        cycle(1'b1, 1'b1, 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        check("slt_m1", alu_result, 32'd1);

        // Independent adder
        cycle(1'b1, 1'b1, 2'b10, 6'h24, 32'd0, 32'd0, 32'd4, 32'h0040_0000);
        check("pc_add", add_sum, 32'h0040_0004);
        cycle(1'b1, 1'b1, 2'b01, 6'h00, 32'd3, 32'd1, 32'hFFFF_FFFC, 32'd8);
        check("pc_wrap", add_sum, 32'd4);

        // Handshake pattern 1,1,0,1 with hold during the idle cycle
        cycle(1'b1, 1'b1, 2'b00, 6'h00, 32'd10, 32'd20, 32'd1, 32'd2);
        cycle(1'b1, 1'b1, 2'b01, 6'h00, 32'd10, 32'd20, 32'd3, 32'd4);
        cycle(1'b1, 1'b0, 2'b00, 6'h00, 32'd99, 32'd99, 32'd99, 32'd99);
        check("hold_result", alu_result, 32'hFFFF_FFF6);
        cycle(1'b1, 1'b1, 2'b10, 6'h25, 32'd1, 32'd2, 32'd5, 32'd6);

        // Mid-stream reset drops the in-flight result
        cycle(1'b1, 1'b1, 2'b00, 6'h00, 32'd7, 32'd8, 32'd9, 32'd9);
        cycle(1'b0, 1'b1, 2'b00, 6'h00, 32'd1, 32'd1, 32'd1, 32'd1);
        cycle(1'b1, 1'b0, 2'b00, 6'h00, 32'd2, 32'd2, 32'd2, 32'd2);
        cycle(1'b1, 1'b1, 2'b00, 6'h00, 32'd3, 32'd4, 32'd5, 32'd6);

        // Random traffic
        for (int i = 0; i < 60; i++)
            cycle(1'b1, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  fl[$urandom_range(0, 6)], $urandom, $urandom, $urandom, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
